// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader.
// Contents:
//   loader_state_t  - record-parser states
//   SYNC_BYTE       - byte that opens a record
//   LEN_ZERO_MEANS  - payload length encoded by a len field of 0
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StLen,
        StData,
        StCsum
    } loader_state_t;

    localparam logic [7:0]  SYNC_BYTE      = 8'h55;
    localparam int unsigned LEN_ZERO_MEANS = 256;

endpackage

// File: rtl/bram_serial_loader_if.sv
// Bundle of the loader's byte-input, RAM port B and status signals.
// Modports:
//   slave  - the loader: consumes rx_valid/rx_data, drives port B and status
//   master - the environment: drives the byte stream, observes port B and status
// Signals:
//   rx_valid, rx_data        byte strobe and byte from the UART receiver
//   b_en, b_wr, b_addr, b_din RAM port B write side
//   cpu_halt                  halts the CPU while a record is in flight
//   load_done, load_err       completion pulse / sticky error flag
interface bram_serial_loader_if #(
    parameter int unsigned DATA = 8,
    parameter int unsigned ADDR = 15
);
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            b_en;
    logic            b_wr;
    logic [ADDR-1:0] b_addr;
    logic [DATA-1:0] b_din;
    logic            cpu_halt;
    logic            load_done;
    logic            load_err;

    modport slave (
        input  rx_valid, rx_data,
        output b_en, b_wr, b_addr, b_din, cpu_halt, load_done, load_err
    );

    modport master (
        output rx_valid, rx_data,
        input  b_en, b_wr, b_addr, b_din, cpu_halt, load_done, load_err
    );
endinterface

// File: rtl/bram_serial_loader.sv
// Byte-stream program loader feeding port B of the CPU dual-port RAM.
// Parses records: 0x55, addr_hi, addr_lo, len (0 = 256), len data bytes, csum.
// Every payload byte is written to RAM; the 8-bit sum of all fields after the
// sync byte (including csum) must be zero for the record to be good.
// Ports:
//   clk  - sole clock (RAM port B shares it)
//   rst  - asynchronous, active-high reset
//   bus  - slave side of bram_serial_loader_if (byte input, port B, status)
// All outputs are registered.
module bram_serial_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA    = 8,
    parameter int unsigned ADDR    = 15,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_serial_loader_if.slave  bus
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    loader_state_t   r_state, w_state_nxt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [7:0]      r_sum;
    logic [7:0]      r_addr_hi;
    logic [ADDR-1:0] r_ptr;
    logic [8:0]      r_remain;

    logic            r_b_en, r_b_wr, r_halt, r_done, r_err;
    logic [ADDR-1:0] r_b_addr;
    logic [DATA-1:0] r_b_din;

    logic            w_b_en_nxt, w_b_wr_nxt, w_halt_nxt, w_done_nxt, w_err_nxt;
    logic [ADDR-1:0] w_b_addr_nxt;
    logic [DATA-1:0] w_b_din_nxt;

    logic            w_timeout;
    logic [7:0]      w_sum_add;

    assign w_sum_add = r_sum + bus.rx_data;

    // An arriving byte always beats an expiring timer.
    assign w_timeout = (r_state != StIdle) && !bus.rx_valid
                       && (r_tmo_cnt == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = StIdle;
        end else if (bus.rx_valid) begin
            case (r_state)
                StIdle:   if (bus.rx_data == SYNC_BYTE) w_state_nxt = StAddrHi;
                StAddrHi: w_state_nxt = StAddrLo;
                StAddrLo: w_state_nxt = StLen;
                StLen:    w_state_nxt = StData;
                StData:   if (r_remain == 9'd1) w_state_nxt = StCsum;
                StCsum:   w_state_nxt = StIdle;
                default:  w_state_nxt = StIdle;
            endcase
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        w_b_en_nxt   = 1'b0;
        w_b_wr_nxt   = 1'b0;
        w_b_addr_nxt = r_b_addr;
        w_b_din_nxt  = r_b_din;
        w_halt_nxt   = r_halt;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;
        if (w_timeout) begin
            w_halt_nxt = 1'b0;
            w_err_nxt  = 1'b1;
        end else if (bus.rx_valid) begin
            case (r_state)
                StIdle: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        w_halt_nxt = 1'b1;
                        w_err_nxt  = 1'b0;
                    end
                end
                StData: begin
                    w_b_en_nxt   = 1'b1;
                    w_b_wr_nxt   = 1'b1;
                    w_b_addr_nxt = r_ptr;
                    w_b_din_nxt  = DATA'(bus.rx_data);
                end
                StCsum: begin
                    w_halt_nxt = 1'b0;
                    if (w_sum_add == 8'h00) w_done_nxt = 1'b1;
                    else                    w_err_nxt  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output registers and record datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_en    <= 1'b0;
            r_b_wr    <= 1'b0;
            r_b_addr  <= '0;
            r_b_din   <= '0;
            r_halt    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tmo_cnt <= '0;
            r_sum     <= 8'h00;
            r_addr_hi <= 8'h00;
            r_ptr     <= '0;
            r_remain  <= 9'd0;
        end else begin
            r_b_en   <= w_b_en_nxt;
            r_b_wr   <= w_b_wr_nxt;
            r_b_addr <= w_b_addr_nxt;
            r_b_din  <= w_b_din_nxt;
            r_halt   <= w_halt_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;

            // Counts idle cycles inside a record; parked at zero in IDLE.
            if (w_state_nxt == StIdle || bus.rx_valid) r_tmo_cnt <= '0;
            else                                       r_tmo_cnt <= r_tmo_cnt + TW'(1);

            if (bus.rx_valid) begin
                case (r_state)
                    StIdle: begin
                        if (bus.rx_data == SYNC_BYTE) r_sum <= 8'h00;
                    end
                    StAddrHi: begin
                        r_addr_hi <= bus.rx_data;
                        r_sum     <= w_sum_add;
                    end
                    StAddrLo: begin
                        r_ptr <= ADDR'({r_addr_hi, bus.rx_data});
                        r_sum <= w_sum_add;
                    end
                    StLen: begin
                        r_remain <= (bus.rx_data == 8'h00) ? 9'(LEN_ZERO_MEANS)
                                                           : {1'b0, bus.rx_data};
                        r_sum    <= w_sum_add;
                    end
                    StData: begin
                        r_ptr    <= r_ptr + ADDR'(1);
                        r_remain <= r_remain - 9'd1;
                        r_sum    <= w_sum_add;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.b_en      = r_b_en;
    assign bus.b_wr      = r_b_wr;
    assign bus.b_addr    = r_b_addr;
    assign bus.b_din     = r_b_din;
    assign bus.cpu_halt  = r_halt;
    assign bus.load_done = r_done;
    assign bus.load_err  = r_err;

endmodule

// File: tb/tb_bram_serial_loader.sv
// Self-checking bench for bram_serial_loader.
// Stimulus tasks describe whole records; the model derives the expected RAM
// writes, halt, done and error behaviour from the record contents and a
// per-cycle compare process checks the DUT against it on every falling edge.
module tb_bram_serial_loader;

    localparam int unsigned DATA    = 8;
    localparam int unsigned ADDR    = 15;
    localparam int unsigned TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_serial_loader_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

    bram_serial_loader #(
        .DATA    (DATA),
        .ADDR    (ADDR),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state
    logic            exp_halt = 1'b0;
    logic            exp_err  = 1'b0;
    logic            exp_done = 1'b0;
    logic [ADDR-1:0] q_addr[$];
    logic [7:0]      q_data[$];
    logic [7:0]      payload[$];

    // Observations
    int              wr_count   = 0;
    int              done_count = 0;
    logic [ADDR-1:0] wr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cpu_halt", 32'(bus.cpu_halt), 32'(exp_halt));
        chk("load_err", 32'(bus.load_err), 32'(exp_err));
        chk("load_done", 32'(bus.load_done), 32'(exp_done));
        chk("b_en_with_b_wr", 32'(bus.b_en), 32'(bus.b_wr));
        if (bus.load_done) done_count++;
        if (bus.b_wr) begin
            chk("write_expected", 32'(q_addr.size() != 0), 32'd1);
            if (q_addr.size() != 0) begin
                chk("b_addr", 32'(bus.b_addr), 32'(q_addr[0]));
                chk("b_din", 32'(bus.b_din), 32'(q_data[0]));
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            wr_count++;
            wr_log.push_back(bus.b_addr);
        end else begin
            chk("missing_write", 32'(q_addr.size()), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        exp_done     = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
    endtask

    // Checksum that makes the 8-bit sum of the record (csum included) zero.
    function automatic logic [7:0] rec_csum(input logic [15:0] addr, input logic [7:0] len);
        logic [7:0] s;
        s = addr[15:8] + addr[7:0] + len;
        foreach (payload[i]) s = s + payload[i];
        return 8'h00 - s;
    endfunction

    // Sends a full record carrying 'payload'; csum is off by 'adj' when nonzero.
    task automatic send_record(input logic [15:0] addr, input logic [7:0] len,
                               input logic [7:0] adj);
        logic [ADDR-1:0] a;
        logic [7:0]      cs;
        cs = rec_csum(addr, len) + adj;
        send(8'h55);
        exp_halt = 1'b1;
        exp_err  = 1'b0;
        send(addr[15:8]);
        send(addr[7:0]);
        send(len);
        a = addr[ADDR-1:0];
        foreach (payload[i]) begin
            send(payload[i]);
            q_addr.push_back(a);
            q_data.push_back(payload[i]);
            a = a + ADDR'(1);
        end
        send(cs);
        exp_halt = 1'b0;
        if (adj == 8'h00) exp_done = 1'b1;
        else              exp_err  = 1'b1;
    endtask

    int wc0;
    int dc0;

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_b_en", 32'(bus.b_en), 32'd0);
        chk("rst_b_wr", 32'(bus.b_wr), 32'd0);
        chk("rst_b_addr", 32'(bus.b_addr), 32'd0);
        chk("rst_b_din", 32'(bus.b_din), 32'd0);
        chk("rst_cpu_halt", 32'(bus.cpu_halt), 32'd0);
        chk("rst_load_done", 32'(bus.load_done), 32'd0);
        chk("rst_load_err", 32'(bus.load_err), 32'd0);
        rst = 1'b0;
        tick();

        // Good record: AA BB CC at 0x1000
        payload = '{8'hAA, 8'hBB, 8'hCC};
        chk("rec1_csum_value", 32'(rec_csum(16'h1000, 8'h03)), 32'hBC);
        wc0 = wr_count;
        dc0 = done_count;
        send_record(16'h1000, 8'h03, 8'h00);
        tick();
        chk("rec1_writes", 32'(wr_count - wc0), 32'd3);
        chk("rec1_done_pulses", 32'(done_count - dc0), 32'd1);
        chk("rec1_last_addr", 32'(wr_log[wr_log.size()-1]), 32'h1002);

        // Same record, checksum off by one
        wc0 = wr_count;
        dc0 = done_count;
        send_record(16'h1000, 8'h03, 8'h01);
        tick();
        chk("rec2_writes", 32'(wr_count - wc0), 32'd3);
        chk("rec2_no_done", 32'(done_count - dc0), 32'd0);
        chk("rec2_err_set", 32'(bus.load_err), 32'd1);

        // Address wrap at 0x7FFF; the sync byte also clears the error
        payload = '{8'hD1, 8'hD2};
        chk("rec3_csum_value", 32'(rec_csum(16'h7FFF, 8'h02)), 32'hDD);
        wc0 = wr_count;
        send_record(16'h7FFF, 8'h02, 8'h00);
        tick();
        chk("rec3_err_cleared", 32'(bus.load_err), 32'd0);
        chk("rec3_first_addr", 32'(wr_log[wc0]), 32'h7FFF);
        chk("rec3_wrap_addr", 32'(wr_log[wc0+1]), 32'h0000);

        // len 0 = 256 back-to-back bytes
        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'(i) ^ 8'h5A);
        wc0 = wr_count;
        send_record(16'h2000, 8'h00, 8'h00);
        tick();
        chk("rec4_writes", 32'(wr_count - wc0), 32'd256);
        chk("rec4_last_addr", 32'(wr_log[wr_log.size()-1]), 32'h20FF);

        // Timeout after one data byte
        send(8'h55);
        exp_halt = 1'b1;
        exp_err  = 1'b0;
        send(8'h10);
        send(8'h00);
        send(8'h03);
        send(8'hAA);
        q_addr.push_back(15'h1000);
        q_data.push_back(8'hAA);
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            tick();
            if (k == int'(TIMEOUT)) begin
                exp_halt = 1'b0;
                exp_err  = 1'b1;
            end
            if (k == int'(TIMEOUT) - 1) chk("tmo_still_halted", 32'(bus.cpu_halt), 32'd1);
        end
        chk("tmo_halt_dropped", 32'(bus.cpu_halt), 32'd0);
        chk("tmo_err_set", 32'(bus.load_err), 32'd1);
        wc0 = wr_count;
        send(8'hAA);
        send(8'h12);
        send(8'h03);
        repeat (3) tick();
        chk("garbage_no_writes", 32'(wr_count - wc0), 32'd0);

        // Good record again clears the error
        payload = '{8'h01, 8'h02, 8'h03};
        send_record(16'h0100, 8'h03, 8'h00);
        tick();
        chk("rec5_err_cleared", 32'(bus.load_err), 32'd0);

        // Reset in the middle of DATA
        send(8'h55);
        exp_halt = 1'b1;
        send(8'h30);
        send(8'h00);
        send(8'h05);
        send(8'h11);
        q_addr.push_back(15'h3000);
        q_data.push_back(8'h11);
        send(8'h22);
        q_addr.push_back(15'h3001);
        q_data.push_back(8'h22);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        exp_halt = 1'b0;
        exp_err  = 1'b0;
        #1;
        chk("midrst_b_en", 32'(bus.b_en), 32'd0);
        chk("midrst_b_addr", 32'(bus.b_addr), 32'd0);
        chk("midrst_b_din", 32'(bus.b_din), 32'd0);
        chk("midrst_cpu_halt", 32'(bus.cpu_halt), 32'd0);
        chk("midrst_load_err", 32'(bus.load_err), 32'd0);
        tick();
        rst = 1'b0;
        wc0 = wr_count;
        send(8'h33);
        send(8'h44);
        send(8'h10);
        repeat (3) tick();
        chk("postrst_no_writes", 32'(wr_count - wc0), 32'd0);

        // Recovery after reset
        payload = '{8'h9C};
        dc0 = done_count;
        send_record(16'h0040, 8'h01, 8'h00);
        repeat (2) tick();
        chk("rec6_done_pulses", 32'(done_count - dc0), 32'd1);
        chk("queue_drained", 32'(q_addr.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_serial_loader.md
# bram_serial_loader

Byte-stream program loader that sits directly upstream of port B of the CPU dual-port RAM. It parses framed records from a byte source (UART receiver), writes each payload byte into RAM through port B, and holds the 6809 in halt while a record is in flight. It verifies a per-record checksum and reports completion or error.

## Interface
- `DATA`, 8, RAM data width; must be 8.
- `ADDR`, 15, RAM address width; record addresses are truncated to `ADDR` bits.
- `TIMEOUT`, 1_000_000, maximum idle clock cycles between bytes inside a record before it is aborted.
- `clk`  in  1  sole clock; RAM port B runs on the same clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `rx_data`  in  8  received byte.
- `b_en`  out  1  RAM port B enable; asserted together with `b_wr`.
- `b_wr`  out  1  RAM port B write strobe.
- `b_addr`  out  ADDR  RAM port B address.
- `b_din`  out  DATA  RAM port B write data.
- `cpu_halt`  out  1  high from sync byte accepted until record end or abort.
- `load_done`  out  1  one-cycle pulse: record complete, checksum good.
- `load_err`  out  1  sticky; set on bad checksum or timeout, cleared on next sync byte.

## Operation
- Record format: `0x55` sync, addr_hi, addr_lo, len (0 means 256), len data bytes, csum.
- Checksum: 8-bit sum of addr_hi, addr_lo, len, all data, and csum must equal `0x00`.
- FSM states: IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM.
  - IDLE: byte `0x55` -> ADDR_HI, set `cpu_halt`, clear `load_err`, clear sum; any other byte ignored.
  - ADDR_HI / ADDR_LO / LEN: latch field, add to sum, advance.
  - DATA: each byte issues one write at current address, adds to sum, increments address mod 2^ADDR, decrements remaining count; after the last byte -> CSUM.
  - CSUM: add byte; sum == 0 -> pulse `load_done`, else set `load_err`; both -> IDLE, drop `cpu_halt`.
- Writes are never rolled back; a bad checksum only flags `load_err`.
- `0x55` is not special outside IDLE; it is treated as an ordinary field or data byte.
- Timeout: a counter clears on every `rx_valid` and counts in every non-IDLE state. At `TIMEOUT` cycles -> IDLE, set `load_err`, drop `cpu_halt`; the partial record is abandoned.
- A reset mid-record returns to IDLE immediately. A partially written record stays in RAM.

## Timing
- Reset values: `b_en`=0, `b_wr`=0, `b_addr`=0, `b_din`=0, `cpu_halt`=0, `load_done`=0, `load_err`=0; FSM IDLE.
- All outputs are registered.
- Write latency: `rx_valid` at cycle N in DATA -> `b_en`/`b_wr` high for exactly cycle N+1, with `b_addr`/`b_din` valid in that cycle. `b_addr` holds its last value otherwise.
- Back-to-back `rx_valid` on consecutive cycles is supported at one write per cycle.
- `cpu_halt` rises the cycle after the sync byte's `rx_valid`.
- `cpu_halt` falls, and `load_done` or `load_err` updates, the cycle after the csum byte's `rx_valid`. This is at least one cycle after the final RAM write.
- Timeout and a byte arriving in the same cycle: the byte wins and the counter clears.

## Structure
- Shared package `loader_pkg`: state enum `loader_state_t`, constants `SYNC_BYTE`=8'h55 and `LEN_ZERO_MEANS`=256.
- One flat module; no sub-modules. The timeout counter is inline, with width $clog2(TIMEOUT+1).

## Test plan
- Record 55 10 00 03 AA BB CC, csum = two's complement of sum -> writes AA@0x1000, BB@0x1001, CC@0x1002 on three one-cycle `b_wr` pulses; `load_done` pulses once; `cpu_halt` high throughout.
- Same record with csum off by 1 -> all three writes occur, `load_err`=1, no `load_done`; next `0x55` clears `load_err`.
- addr 7F FF, len 02, ADDR=15 -> writes at 0x7FFF then 0x0000 (wrap).
- len 00 with 256 back-to-back bytes -> exactly 256 writes, consecutive addresses, no gaps.
- Stream stops after 1 data byte, TIMEOUT=100 -> 100 cycles later FSM IDLE, `cpu_halt`=0, `load_err`=1; garbage bytes before next `0x55` cause no writes.
- Assert `rst` during DATA -> all outputs 0 immediately; no further writes until a new sync byte.
